// File: rtl/booth_pp_reducer.sv
// Sequential radix-4 Booth partial-product reducer: two CSA rows per cycle into a
// carry-save accumulator, then one carry-propagate add, with valid/ready on both sides.

module booth_csa #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] s,
  output logic [W-1:0] cy
);
  logic [W-1:0] maj;

  assign s   = a ^ b ^ c;
  assign maj = (a & b) | (a & c) | (b & c);
  // Carry weight is one bit up; the MSB carry falls off (mod 2^W).
  assign cy  = maj << 1;
endmodule

module booth_pp_reducer #(
  parameter  int WIDTH_A = 16,
  parameter  int WIDTH_B = 16,
  localparam int COUNT   = (WIDTH_B + 2) / 2,
  localparam int WIDTH_O = WIDTH_A + WIDTH_B,
  localparam int NSTEP   = (COUNT + 1) / 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic [COUNT-1:0][WIDTH_O-1:0]   partial_prods_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [WIDTH_O-1:0]              product_o,
  output logic                            busy_o
);
  localparam int STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int PADN   = 1 << (STEP_W + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);

  typedef enum logic [1:0] {IDLE, REDUCE, ADD, DONE} state_t;

  state_t                           state;
  logic [STEP_W-1:0]                step;
  logic [COUNT-1:0][WIDTH_O-1:0]    pp_buf;
  logic [WIDTH_O-1:0]               sum, carry;
  logic [PADN-1:0][WIDTH_O-1:0]     pp_pad;
  logic [WIDTH_O-1:0]               pp_a, pp_b;
  logic [WIDTH_O-1:0]               s1, c1, s2, c2;

  // Pad to a power of two so the step-indexed pair never reads past the buffer;
  // the slot after an odd last partial product reads as zero.
  for (genvar i = 0; i < PADN; i++) begin : g_pad
    if (i < COUNT) begin : g_pp
      assign pp_pad[i] = pp_buf[i];
    end else begin : g_zero
      assign pp_pad[i] = '0;
    end
  end

  assign pp_a = pp_pad[{step, 1'b0}];
  assign pp_b = pp_pad[{step, 1'b1}];

  booth_csa #(.W(WIDTH_O)) u_row0 (.a(sum), .b(carry), .c(pp_a), .s(s1), .cy(c1));
  booth_csa #(.W(WIDTH_O)) u_row1 (.a(s1),  .b(c1),    .c(pp_b), .s(s2), .cy(c2));

  assign in_ready_o = (state == IDLE);
  assign busy_o     = (state == REDUCE) || (state == ADD);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      step        <= '0;
      pp_buf      <= '0;
      sum         <= '0;
      carry       <= '0;
      product_o   <= '0;
      out_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            pp_buf <= partial_prods_i;
            sum    <= '0;
            carry  <= '0;
            step   <= '0;
            state  <= REDUCE;
          end
        end
        REDUCE: begin
          sum   <= s2;
          carry <= c2;
          step  <= step + STEP_W'(1);
          if (step == LAST_STEP) state <= ADD;
        end
        ADD: begin
          product_o   <= sum + carry;
          out_valid_o <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_pp_reducer.sv
// Scoreboard bench for booth_pp_reducer: stimulus pushes expected products, a
// negedge monitor pops and compares on every output handshake.

module tb_booth_pp_reducer;
  localparam int WA    = 16;
  localparam int WB    = 16;
  localparam int COUNT = (WB + 2) / 2;
  localparam int WO    = WA + WB;
  localparam int LAT   = 6;
  localparam int II    = 8;

  typedef logic [COUNT-1:0][WO-1:0] pp_t;
  typedef struct {
    logic [WO-1:0] exp;
    int            acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  pp_t           pp_drv = '0;
  logic          in_ready, out_valid, busy;
  logic [WO-1:0] product;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  bit   b2b = 1'b0;
  int   last_acc = -1;
  logic prev_valid = 1'b0;
  int   waited;

  booth_pp_reducer #(.WIDTH_A(WA), .WIDTH_B(WB)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .partial_prods_i(pp_drv),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .product_o      (product),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [WO-1:0] act, input logic [WO-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Radix-4 Booth digits over {00,B,0}, each partial product sign-extended to WO bits.
  function automatic pp_t booth_pp(input logic [WA-1:0] a, input logic [WB-1:0] b);
    logic [WB+2:0] bx;
    logic [WO-1:0] m, v;
    logic [2:0]    t;
    pp_t           r;
    bx = {2'b00, b, 1'b0};
    m  = WO'(a);
    for (int i = 0; i < COUNT; i++) begin
      t = bx[2*i +: 3];
      case (t)
        3'b001, 3'b010: v = m;
        3'b011:         v = m << 1;
        3'b100:         v = -(m << 1);
        3'b101, 3'b110: v = -m;
        default:        v = '0;
      endcase
      r[i] = v << (2 * i);
    end
    return r;
  endfunction

  // Called at posedge+1; leaves in_valid high, returns at posedge+1 after the accept edge.
  task automatic send(input logic [WA-1:0] a, input logic [WB-1:0] b,
                      input logic [WO-1:0] exp, output int wt);
    int acc;
    pp_drv   = booth_pp(a, b);
    in_valid = 1'b1;
    wt       = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        wt = k;
        break;
      end
    end
    if (wt == 0) begin
      fail_now("accept_timeout");
    end else begin
      acc = cyc + 1;
      if (b2b && last_acc >= 0) chk("ii", WO'(acc - last_acc), WO'(II));
      last_acc = acc;
      exp_q.push_back('{exp, acc});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 400; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) fail_now("unexpected_valid");
        else chk("latency", WO'(cyc - exp_q[0].acc), WO'(LAT));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("spurious_output");
        end else begin
          mon_e = exp_q.pop_front();
          chk("product", product, mon_e.exp);
        end
      end
      prev_valid <= out_valid;
    end
  end

  initial begin
    logic [WA-1:0] ra;
    logic [WB-1:0] rb;
    int            got;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", WO'(out_valid), 0);
    chk("rst_busy", WO'(busy), 0);
    chk("rst_product", product, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", WO'(in_ready), 1);

    // Directed vectors
    send(16'h0003, 16'h0005, 32'h0000000F, waited);
    send(16'hFFFF, 16'hFFFF, 32'hFFFE0001, waited);
    send(16'h8000, 16'h8000, 32'h40000000, waited);
    send(16'h0000, 16'h1234, 32'h00000000, waited);
    in_valid = 1'b0;
    wait_drain();

    // Backpressure: result held, a pending request is refused until the handshake
    out_ready = 1'b0;
    send(16'h1234, 16'h5678, 32'h06260060, waited);
    pp_drv = booth_pp(16'd11, 16'd13);
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1;
        break;
      end
    end
    if (got == 0) fail_now("bp_valid_timeout");
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid_held", WO'(out_valid), 1);
      chk("bp_product_held", product, 32'h06260060);
      chk("bp_in_ready_low", WO'(in_ready), 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(16'd11, 16'd13, 32'h0000008F, waited);
    chk("bp_ready_next_cycle", WO'(waited), 2);
    in_valid = 1'b0;
    wait_drain();

    // Input changes after accept must not affect the result
    send(16'h0100, 16'h0100, 32'h00010000, waited);
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      pp_drv = pp_t'({9{$urandom()}});
      @(posedge clk);
      #1;
    end
    wait_drain();

    // Back-to-back with in_valid and out_ready high
    b2b = 1'b1;
    last_acc = -1;
    for (int n = 0; n < 200; n++) begin
      ra = WA'($urandom());
      rb = WB'($urandom());
      send(ra, rb, {16'h0, ra} * {16'h0, rb}, waited);
    end
    in_valid = 1'b0;
    b2b = 1'b0;
    wait_drain();

    // Reset during REDUCE step 2 discards the op
    send(16'h1111, 16'h2222, 32'h0246_8642, waited);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", WO'(out_valid), 0);
    chk("arst_busy", WO'(busy), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_in_ready", WO'(in_ready), 1);
    send(16'd7, 16'd9, 32'h0000003F, waited);
    in_valid = 1'b0;
    wait_drain();
    repeat (12) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
